uart_avalon_slave: RTL and testbench

UART_AVALON_SLAVE -- requirements
Module: uart_avalon_slave

---
 rtl/uart_avalon_slave.sv | 268 ++++++++++++++++++++++++++
 tb/tb_uart_avalon_slave.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_avalon_slave.sv
// UART with an Avalon-MM slave register interface: RX data, TX data and STATUS registers,
// 8N1 framing, independent RX/TX baud counters.
module uart_avalon_slave #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [4:0] ADDR_RX     = 5'd0;
  localparam logic [4:0] ADDR_TX     = 5'd4;
  localparam logic [4:0] ADDR_STATUS = 5'd8;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Register file state
  logic       rx_ok, tx_ok, roe, fe;
  logic [7:0] rx_data;
  logic [7:0] tx_hold;

  // Bus handshake
  logic pending;
  logic req;
  logic access;
  logic rd_rx;
  logic wr_tx;
  logic [31:0] status;

  // RX path
  logic       rx_meta, rx_sync, rx_prev;
  logic       rx_fall;
  rx_state_t  rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0] rx_bit, rx_bit_nxt;
  logic [7:0] rx_shift, rx_shift_nxt;
  logic       rx_done, rx_ferr;

  // TX path
  tx_state_t  tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0] tx_bit, tx_bit_nxt;
  logic [7:0] tx_shift, tx_shift_nxt;
  logic       txd_nxt;
  logic       tx_load;

  logic unused_wdata;
  assign unused_wdata = ^avs_writedata[31:8];

  // Every access stalls exactly one cycle and completes in the second
  assign req    = avs_read | avs_write;
  assign access = pending & req;
  assign rd_rx  = access & avs_read  & (avs_address == ADDR_RX);
  assign wr_tx  = access & avs_write & (avs_address == ADDR_TX);
  assign avs_waitrequest = avm_rst_n & req & ~pending;

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      pending <= 1'b0;
    end else begin
      pending <= req & ~pending;
    end
  end

  assign status = {24'b0, rx_ok, tx_ok, 2'b00, roe, fe, 2'b00};

  always_comb begin
    avs_readdata = '0;
    if (access && avs_read) begin
      case (avs_address)
        ADDR_RX:     avs_readdata = {24'b0, rx_data};
        ADDR_STATUS: avs_readdata = status;
        default:     avs_readdata = '0;
      endcase
    end
  end

  // Two-flop synchronizer plus edge history for start-bit detection
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt + CNT_W'(1);
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_done      = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nxt = '0;
        rx_bit_nxt = '0;
        if (rx_fall) rx_state_nxt = RX_START;
      end
      RX_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_done      = rx_sync;
          rx_ferr      = ~rx_sync;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: begin
        rx_cnt_nxt   = '0;
        rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  // Flags and data registers; a new byte wins over a same-cycle RX read
  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      rx_ok   <= 1'b0;
      tx_ok   <= 1'b1;
      roe     <= 1'b0;
      fe      <= 1'b0;
      rx_data <= '0;
      tx_hold <= '0;
    end else begin
      if (rd_rx) begin
        rx_ok <= 1'b0;
        roe   <= 1'b0;
        fe    <= 1'b0;
      end
      if (rx_done) begin
        if (!rx_ok || rd_rx) begin
          rx_data <= rx_shift;
          rx_ok   <= 1'b1;
        end else begin
          roe <= 1'b1;
        end
      end
      if (rx_ferr) fe <= 1'b1;
      if (tx_load) tx_ok <= 1'b1;
      if (wr_tx && tx_ok) begin
        tx_hold <= avs_writedata[7:0];
        tx_ok   <= 1'b0;
      end
    end
  end

  always_ff @(posedge avm_clk or negedge avm_rst_n) begin
    if (!avm_rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      uart_txd <= txd_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt + CNT_W'(1);
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_load      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nxt = '0;
        tx_bit_nxt = '0;
        if (!tx_ok) begin
          tx_load      = 1'b1;
          tx_shift_nxt = tx_hold;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          tx_bit_nxt   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
        end
      end
      TX_STOP: begin
        // A waiting byte chains straight into the next start bit
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt = '0;
          if (!tx_ok) begin
            tx_load      = 1'b1;
            tx_shift_nxt = tx_hold;
            tx_state_nxt = TX_START;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: begin
        tx_cnt_nxt   = '0;
        tx_state_nxt = TX_IDLE;
      end
    endcase
  end

  always_comb begin
    case (tx_state_nxt)
      TX_START: txd_nxt = 1'b0;
      TX_DATA:  txd_nxt = tx_shift_nxt[0];
      default:  txd_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_avalon_slave.sv
// Bench for uart_avalon_slave: directed and random RX/TX frames against a flag-level
// register model and a serial-line collector.
module tb_uart_avalon_slave;

  localparam int unsigned CPB = 4;

  logic        clk;
  logic        rst_n;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic        uart_rxd;
  logic        uart_txd;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  uart_avalon_slave #(.CLKS_PER_BIT(CPB)) dut (
    .avm_clk        (clk),
    .avm_rst_n      (rst_n),
    .avs_address    (avs_address),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_waitrequest(avs_waitrequest),
    .uart_rxd       (uart_rxd),
    .uart_txd       (uart_txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the register-visible state
  logic       m_rx_ok, m_tx_ok, m_roe, m_fe, m_known;
  logic [7:0] m_rx_data;

  function automatic logic [31:0] status_exp();
    return {24'b0, m_rx_ok, m_tx_ok, 2'b00, m_roe, m_fe, 2'b00};
  endfunction

  task automatic model_reset();
    m_rx_ok = 1'b0; m_tx_ok = 1'b1; m_roe = 1'b0; m_fe = 1'b0; m_known = 1'b0;
    m_rx_data = 8'h00;
  endtask

  // Serial-line collector: decodes frames on uart_txd at mid-bit
  logic [7:0]  tx_q[$];
  int unsigned tx_t[$];
  int          tx_bad = 0;

  initial begin
    logic [7:0] b;
    int unsigned t;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_txd === 1'b0) begin
        t = cyc;
        @(negedge clk);
        if (uart_txd !== 1'b0) tx_bad++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        if (uart_txd !== 1'b1) tx_bad++;
        tx_q.push_back(b);
        tx_t.push_back(t);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, input string tag);
    int n;
    n = 0;
    avs_address = addr; avs_writedata = wdata; avs_read = ~wr; avs_write = wr;
    #1;
    check({tag, "_wait1"}, 32'(avs_waitrequest), 32'd1);
    @(posedge clk); #1;
    check({tag, "_wait2"}, 32'(avs_waitrequest), 32'd0);
    while (avs_waitrequest === 1'b1 && n < 8) begin
      step();
      n++;
    end
    rdata = avs_readdata;
    step();
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data, input string tag);
    logic [31:0] dummy;
    bus(1'b1, addr, {24'hDEAD_BE, data}, dummy, tag);
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] d;
    bus(1'b0, 5'd8, 32'h0, d, tag);
    check(tag, d, status_exp());
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] d;
    bus(1'b0, 5'd0, 32'h0, d, tag);
    if (m_known) check(tag, d, {24'b0, m_rx_data});
    m_rx_ok = 1'b0; m_roe = 1'b0; m_fe = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (CPB) step();
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) step();
    end
    uart_rxd = stop;
    repeat (CPB) step();
    uart_rxd = 1'b1;
    repeat (3 * CPB) step();
    if (!stop) m_fe = 1'b1;
    else if (!m_rx_ok) begin
      m_rx_data = b; m_rx_ok = 1'b1; m_known = 1'b1;
    end else m_roe = 1'b1;
  endtask

  task automatic tx_pair(input logic [7:0] b0, input logic [7:0] b1, input string tag);
    int n;
    logic [7:0] got;
    int unsigned t0, t1;
    tx_q.delete(); tx_t.delete(); tx_bad = 0;
    wr(5'd4, b0, {tag, "_wr0"});
    wr(5'd4, b1, {tag, "_wr1"});
    m_tx_ok = 1'b0;
    rd_status({tag, "_busy"});
    wr(5'd4, ~b0, {tag, "_wr2"});
    rd_status({tag, "_drop"});
    n = 0;
    while (tx_q.size() < 2 && n < 400) begin
      step();
      n++;
    end
    check({tag, "_nframes"}, 32'(tx_q.size()), 32'd2);
    got = 8'hxx; t0 = 0; t1 = 0;
    if (tx_q.size() > 0) begin got = tx_q.pop_front(); t0 = tx_t.pop_front(); end
    check({tag, "_byte0"}, {24'b0, got}, {24'b0, b0});
    got = 8'hxx;
    if (tx_q.size() > 0) begin got = tx_q.pop_front(); t1 = tx_t.pop_front(); end
    check({tag, "_byte1"}, {24'b0, got}, {24'b0, b1});
    check({tag, "_gap"}, 32'(t1 - t0), 32'(10 * CPB));
    check({tag, "_framing"}, 32'(tx_bad), 32'd0);
    repeat (12 * CPB) step();
    check({tag, "_no_third"}, 32'(tx_q.size()), 32'd0);
    m_tx_ok = 1'b1;
    rd_status({tag, "_idle"});
  endtask

  initial begin
    logic [7:0] b, b2;
    int kind;
    rst_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; uart_rxd = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    avs_read = 1'b1; avs_address = 5'd8;
    #1;
    check("rst_wait", 32'(avs_waitrequest), 32'd0);
    check("rst_rdata", avs_readdata, 32'd0);
    check("rst_txd", 32'(uart_txd), 32'd1);
    avs_read = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();

    rd_status("status_reset");

    send_frame(8'hA5, 1'b1);
    rd_status("status_a5");
    rd_rx("rx_a5");
    rd_status("status_a5_read");

    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rd_status("status_overrun");
    rd_rx("rx_11");
    rd_status("status_overrun_read");

    send_frame(8'h3C, 1'b0);
    rd_status("status_fe");
    rd_rx("rx_fe");
    rd_status("status_fe_read");

    uart_rxd = 1'b0;
    step();
    uart_rxd = 1'b1;
    repeat (4 * CPB) step();
    rd_status("status_glitch");
    b = 8'($urandom);
    send_frame(b, 1'b1);
    rd_rx("rx_after_glitch");

    tx_pair(8'h53, 8'h0F, "tx_dir");
    tx_pair(8'($urandom), 8'($urandom), "tx_rnd");

    for (int it = 0; it < 6; it++) begin
      kind = int'($urandom_range(0, 2));
      b  = 8'($urandom);
      b2 = 8'($urandom);
      if (kind == 0) send_frame(b, 1'b1);
      else if (kind == 1) begin send_frame(b, 1'b1); send_frame(b2, 1'b1); end
      else begin send_frame(b, 1'b0); send_frame(b2, 1'b1); end
      rd_status("rnd_status");
      rd_rx("rnd_rx");
      rd_status("rnd_status_read");
    end

    // Reset in the middle of both a TX frame and an RX frame
    wr(5'd4, 8'h81, "mid_wr");
    uart_rxd = 1'b0;
    repeat (10) step();
    avs_read = 1'b1; avs_address = 5'd8;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(uart_txd), 32'd1);
    check("midrst_wait", 32'(avs_waitrequest), 32'd0);
    check("midrst_rdata", avs_readdata, 32'd0);
    avs_read = 1'b0;
    uart_rxd = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (12 * CPB) step();
    tx_q.delete(); tx_t.delete(); tx_bad = 0;
    model_reset();
    rd_status("status_after_midrst");
    b = 8'($urandom);
    send_frame(b, 1'b1);
    rd_rx("rx_after_midrst");
    rd_status("status_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
